// File: rtl/lp_interp2.sv
// lp_interp2: signed 2x linear-interpolating upsampler (x0, m01, x1, m12, x2, ...).
// Build option: define LP_INTERP_ROUND_EN to round midpoints half toward +inf
// instead of flooring them.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous flush back to the unprimed state
//   in_valid   din is valid
//   in_ready   block can accept din this cycle
//   din        signed input sample
//   out_valid  dout is valid (registered)
//   out_ready  consumer takes dout this cycle
//   dout       signed output sample (registered)
module lp_interp2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dout
);
    typedef enum logic [1:0] {EMPTY, SMP, WAIT, MID} state_t;

`ifdef LP_INTERP_ROUND_EN
    localparam logic [DW:0] rnd = 1;
`else
    localparam logic [DW:0] rnd = 0;
`endif

    state_t        state_q, state_d;
    logic [DW-1:0] cur_q, cur_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ov_q, ov_d;
    logic          in_xfer, out_xfer;

    // One extra bit of headroom makes the sum exact; dropping the LSB is the
    // arithmetic shift, so the result always fits back into DW bits.
    function automatic logic [DW-1:0] mid(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b} + rnd;
        return s[DW:1];
    endfunction

    assign in_ready  = !clr && (state_q == EMPTY || state_q == WAIT ? 1'b1 :
                                state_q == SMP ? out_ready : 1'b0);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = ov_q && out_ready;
    assign out_valid = ov_q;
    assign dout      = dout_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dout_d  = dout_q;
        ov_d    = ov_q;
        case (state_q)
            EMPTY: if (in_xfer) begin
                cur_d   = din;
                dout_d  = din;
                ov_d    = 1'b1;
                state_d = SMP;
            end
            SMP: if (out_xfer && in_xfer) begin
                dout_d  = mid(cur_q, din);
                cur_d   = din;
                state_d = MID;
            end else if (out_xfer) begin
                ov_d    = 1'b0;
                state_d = WAIT;
            end
            WAIT: if (in_xfer) begin
                dout_d  = mid(cur_q, din);
                cur_d   = din;
                ov_d    = 1'b1;
                state_d = MID;
            end
            MID: if (out_xfer) begin
                dout_d  = cur_q;
                state_d = SMP;
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over everything; dout and cur keep their stale contents.
        if (clr) begin
            state_d = EMPTY;
            ov_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cur_q   <= '0;
            dout_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dout_q  <= dout_d;
            ov_q    <= ov_d;
        end
    end
endmodule

// File: tb/tb_lp_interp2.sv
// tb_lp_interp2: self-checking bench for lp_interp2 (directed tables, corner sequences, random scoreboard).
module tb_lp_interp2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] din = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] dout;

    int total = 0;
    int bad = 0;

    lp_interp2 #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    always #5 clk = ~clk;

    function automatic int mid(input int a, input int b);
`ifdef LP_INTERP_ROUND_EN
        return (a + b + 1) >>> 1;
`else
        return (a + b) >>> 1;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sample outputs at the falling edge, then advance past the next rising edge.
    task automatic step(output logic ir, output logic ov, output int d);
        @(negedge clk);
        ir = in_ready;
        ov = out_valid;
        d  = int'($signed(dout));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        in_valid = 1'b1;
        din = x[7:0];
    endtask

    task automatic flush();
        logic ir, ov;
        int d;
        clr = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(ir, ov, d);
        clr = 1'b0;
    endtask

    // Feed a stream at full rate with out_ready=1 and collect every output transfer.
    task automatic run_stream(input string name, input int xs[$], input int exp[$]);
        int got[$];
        int idx = 0;
        logic ir, ov;
        int d;
        flush();
        for (int c = 0; c < 3 * xs.size() + 6; c++) begin
            if (idx < xs.size()) send(xs[idx]);
            else in_valid = 1'b0;
            out_ready = 1'b1;
            step(ir, ov, d);
            if (ov) got.push_back(d);
            if (in_valid && ir) idx++;
        end
        in_valid = 1'b0;
        chk({name, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s out%0d", name, i), got[i], exp[i]);
    endtask

    typedef struct {
        logic iv;
        int   din;
        logic ordy;
        logic ov;
        int   dout;
        logic ir;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic ir, ov;
        int d;
        int exp_q[$];
        logic primed;
        int prev;
        logic held_v;
        int held_d;

        // Reset state
        @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset dout", int'($signed(dout)), 0);
        chk("reset in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stream 10, 20, -20 at full rate, cycle-exact
        tbl[0] = '{1'b1,  10, 1'b1, 1'b0,   0, 1'b1};
        tbl[1] = '{1'b1,  20, 1'b1, 1'b1,  10, 1'b1};
        tbl[2] = '{1'b1, -20, 1'b1, 1'b1,  15, 1'b0};
        tbl[3] = '{1'b1, -20, 1'b1, 1'b1,  20, 1'b1};
        tbl[4] = '{1'b0,   0, 1'b1, 1'b1,   0, 1'b0};
        tbl[5] = '{1'b0,   0, 1'b1, 1'b1, -20, 1'b1};
        tbl[6] = '{1'b0,   0, 1'b1, 1'b0,   0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            in_valid  = tbl[i].iv;
            din       = tbl[i].din[7:0];
            out_ready = tbl[i].ordy;
            step(ir, ov, d);
            chk($sformatf("tbl%0d out_valid", i), int'(ov), int'(tbl[i].ov));
            chk($sformatf("tbl%0d in_ready", i), int'(ir), int'(tbl[i].ir));
            if (tbl[i].ov) chk($sformatf("tbl%0d dout", i), d, tbl[i].dout);
        end

        // Rounding and extremes
`ifdef LP_INTERP_ROUND_EN
        run_stream("round", '{3, 4, -3, -4}, '{3, 4, 4, 1, -3, -3, -4});
        run_stream("extreme", '{127, -128, 127, -128}, '{127, 0, -128, 0, 127, 0, -128});
`else
        run_stream("round", '{3, 4, -3, -4}, '{3, 3, 4, 0, -3, -4, -4});
        run_stream("extreme", '{127, -128, 127, -128}, '{127, -1, -128, -1, 127, -1, -128});
`endif

        // Backpressure in MID
        flush();
        send(10); step(ir, ov, d);
        send(20); step(ir, ov, d);
        send(40);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(ir, ov, d);
            chk($sformatf("bp hold dout c%0d", i), d, 15);
            chk($sformatf("bp hold valid c%0d", i), int'(ov), 1);
            chk($sformatf("bp in_ready c%0d", i), int'(ir), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(ir, ov, d);
        chk("bp release dout", d, 15);
        step(ir, ov, d);
        chk("bp next valid", int'(ov), 1);
        chk("bp next dout", d, 20);

        // Input starvation through WAIT
        flush();
        send(10); step(ir, ov, d);
        send(20); step(ir, ov, d);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step(ir, ov, d);
        chk("starve wait valid", int'(ov), 0);
        chk("starve wait ready", int'(ir), 1);
        send(40); step(ir, ov, d);
        in_valid = 1'b0;
        step(ir, ov, d);
        chk("starve mid valid", int'(ov), 1);
        chk("starve mid dout", d, 30);
        step(ir, ov, d);
        chk("starve smp dout", d, 40);

        // clr in MID discards the pending midpoint
        flush();
        send(10); step(ir, ov, d);
        send(20); step(ir, ov, d);
        send(99);
        clr = 1'b1;
        step(ir, ov, d);
        chk("clr pending dout", d, 15);
        chk("clr in_ready", int'(ir), 0);
        clr = 1'b0;
        send(50); step(ir, ov, d);
        chk("clr after valid", int'(ov), 0);
        in_valid = 1'b0;
        step(ir, ov, d);
        chk("clr first valid", int'(ov), 1);
        chk("clr first dout", d, 50);
        step(ir, ov, d);
        chk("clr single output", int'(ov), 0);

        // Asynchronous reset in MID
        flush();
        send(10); step(ir, ov, d);
        send(20); step(ir, ov, d);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", int'(out_valid), 0);
        chk("arst dout", int'($signed(dout)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(50); step(ir, ov, d);
        in_valid = 1'b0;
        step(ir, ov, d);
        chk("arst first dout", d, 50);
        step(ir, ov, d);
        chk("arst single output", int'(ov), 0);

        // Randomized traffic against a queue-based reference
        flush();
        primed = 1'b0;
        prev = 0;
        held_v = 1'b0;
        held_d = 0;
        for (int c = 0; c < 3000; c++) begin
            clr = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            din = 8'($urandom);
            out_ready = clr ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (held_v) begin
                chk("rnd hold valid", int'(out_valid), 1);
                chk("rnd hold dout", int'($signed(dout)), held_d);
            end
            held_v = out_valid && !out_ready && !clr;
            held_d = int'($signed(dout));
            if (clr) begin
                chk("rnd clr in_ready", int'(in_ready), 0);
                exp_q.delete();
                primed = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("rnd unexpected output", int'($signed(dout)), -999);
                    else chk("rnd dout", int'($signed(dout)), exp_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    if (primed) exp_q.push_back(mid(prev, int'($signed(din))));
                    exp_q.push_back(int'($signed(din)));
                    prev = int'($signed(din));
                    primed = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("drain unexpected output", int'($signed(dout)), -999);
                else chk("drain dout", int'($signed(dout)), exp_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        chk("drain leftover", exp_q.size(), 0);
        @(negedge clk);
        chk("drain out_valid", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lp_interp2.md
# lp_interp2

Signed 2x linear-interpolating upsampler: the reconstruction counterpart to the 1-2-1 decimating low-pass filter in the sample path. It accepts one signed sample per input handshake. For every sample after the first, it emits the midpoint to the previous sample and then the sample itself, so the output stream is x0, m01, x1, m12, x2, …. Both ports use valid/ready handshakes, with a registered output, so the block sits between a rate-reduced stage and a full-rate consumer.

## Interface
- DW, 8 — sample width, two's complement.
- clk  in  1  — sole clock; all state updates on the rising edge.
- rst_n  in  1  — reset, asynchronous, active-low.
- clr  in  1  — synchronous flush; returns the block to the unprimed state.
- in_valid  in  1  — din is valid.
- in_ready  out  1  — block can accept din this cycle (combinational from state and out_ready).
- din  in  DW  — input sample.
- out_valid  out  1  — dout is valid (registered).
- out_ready  in  1  — consumer takes dout this cycle.
- dout  out  DW  — output sample (registered).

## Operation
- Handshake rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, dout and out_valid are held stable.
- Internal register cur (DW bits) holds the last accepted sample.
- Midpoint: mid(a,b) = (sext(a)+sext(b)) >>> 1, computed in DW+1 bits, arithmetic shift, truncated to DW. It cannot overflow.
- State machine:
  - EMPTY: unprimed. out_valid=0, in_ready=1. On accept: cur<=din, dout<=din, out_valid<=1, go to SMP.
  - SMP: presenting cur. in_ready=out_ready.
    - Output transfer with input transfer: dout<=mid(cur,din), cur<=din, go to MID.
    - Output transfer without input: out_valid<=0, go to WAIT.
    - Otherwise: hold.
  - WAIT: primed, output empty. out_valid=0, in_ready=1. On accept: dout<=mid(cur,din), cur<=din, out_valid<=1, go to MID.
  - MID: presenting a midpoint. in_ready=0. On output transfer: dout<=cur, go to SMP.
- clr, synchronous, takes priority over all transitions:
  - Next state EMPTY, out_valid<=0, dout and cur unchanged.
  - in_ready is forced to 0 in the cycle clr is high, so no input is consumed.
- Sample count: the first sample after reset or clr produces exactly one output. Each later sample produces two.

## Timing
- Reset values: state=EMPTY, out_valid=0, dout=0, cur=0, in_ready=1 (given clr=0).
- Latency: input accepted at edge k appears on dout (the sample in EMPTY, the midpoint otherwise) after edge k, i.e. valid in cycle k+1.
- Sustained rate:
  - one input per 2 cycles, one output per cycle, with out_ready=1 and the input always valid.
  - No bubble at the SMP→MID handover.
- Output backpressure stalls input acceptance in SMP and MID with zero loss. No sample is dropped or duplicated.
- Reset asserted mid-stream: state clears immediately (asynchronously), and any partially emitted pair is discarded.
- clr together with in_valid: the input is not accepted.
- clr together with a pending out_valid: the pending output is discarded.

## Configuration
- LP_INTERP_ROUND_EN defined:
  - mid(a,b) = (sext(a)+sext(b)+1) >>> 1, i.e. round half toward +inf, still computed in DW+1 bits.
  - Examples: mid(3,4)=4, mid(-3,-4)=-3, mid(127,127)=127.
- Undefined: floor, as above. Examples: mid(3,4)=3, mid(-3,-4)=-4.
- Handshake, latency and state behaviour are identical in both builds.

## Test plan
- Reset then stream 10, 20, -20 with out_ready=1 and in_valid always high:
  - dout sequence 10, 15, 20, 0, -20.
  - out_valid continuous from the first output.
  - in_ready alternates.
- Midpoint rounding on pairs (3,4) and (-3,-4):
  - floor build: 3, 4, then the pair -3, -4 gives -4 between them.
  - LP_INTERP_ROUND_EN build: 4 and -3.
- Extremes: 127, -128, 127, -128 → 127, -1, -128, -1, 127, -1, -128. No wrap; the ROUND build gives 0 for each midpoint.
- Backpressure: drive out_ready low for 5 cycles while in MID after 10, 20:
  - dout holds 15 and in_ready=0 throughout.
  - After release the output continues 20 with no loss.
- Input starvation: after 10, 20 drop in_valid for 4 cycles:
  - out_valid falls to 0 in WAIT.
  - Next input 40 yields 30, 40 with one-cycle latency.
- clr asserted in MID after 10, 20 (dout=15 pending):
  - out_valid drops and 15 is never transferred.
  - Next input 50 produces the single output 50, no midpoint. Repeat with rst_n pulsed mid-stream for the same result.
